instr_fifo: RTL and testbench
=============================

INSTR_FIFO -- requirements
Module: instr_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entry count; power of two, >= 4.
REQ-002 SHALL have port clk, input, 1: sole clock, all state rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port flush, input, 1: discard all stored entries.
REQ-005 SHALL have port write_en, input, 2: per-slot push request from fetch; bit1 honoured only with bit0.
REQ-006 SHALL have port write_data, input, pipe_entry_t[1:0]: fetched entries, slot0 older.
REQ-007 SHALL have port issue_en, input, 2: pops from issue control; bit1 honoured only with bit0.
REQ-008 SHALL have port read_data, output, pipe_entry_t[1:0]: head entry (slot0) and head+1 (slot1).
REQ-009 SHALL have port read_valid, output, 2: slot holds a stored entry.
REQ-010 SHALL have port fifo_ctrl, output, fifo_ctrl_t: fields empty, almost_empty, full, almost_full.

Function
REQ-011 SHALL keep rptr, wptr (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
REQ-012 SHALL drive fifo_ctrl.empty = (count==0) and almost_empty = (count==1), combinationally from registered count.
REQ-013 SHALL drive fifo_ctrl.full = (count==DEPTH) and almost_full = (count>=DEPTH-1).
REQ-014 SHALL drive read_data[0]=mem[rptr], read_data[1]=mem[rptr+1 mod DEPTH], read_valid[0]=(count>=1), read_valid[1]=(count>=2); zero-latency read, no bypass of same-cycle writes.
REQ-015 SHALL compute pop = 0, 1 or 2 from issue_en per REQ-007, clipped to count.
REQ-016 SHALL compute push from write_en: slot0 accepted if free>=1, slot1 if slot0 accepted and free>=2, with free = DEPTH-count before this cycle's pop.
REQ-017 SHALL write accepted slot0 at wptr, slot1 at wptr+1 mod DEPTH; advance wptr by push, rptr by pop, count += push - pop, all in one edge.
REQ-018 SHALL handle simultaneous push and pop in one cycle, including when count==DEPTH (pop frees space only from the next cycle).
REQ-019 SHALL, on flush, set rptr=wptr=count=0 next edge and drop same-cycle writes and pops; flush has priority.
REQ-020 SHALL preserve order: entries leave in exact push order, slot0 before slot1.
REQ-021 SHALL leave storage array contents unspecified after reset/flush; only read_valid qualifies read_data.

Reset
REQ-022 SHALL on rst asynchronously clear rptr, wptr and count, giving empty=1, almost_empty=0, full=0, almost_full=0, read_valid=0.
REQ-023 SHALL, when rst asserts mid-operation, lose all entries; no pushes accepted while rst high.
REQ-024 SHALL NOT reset the storage array.

Configuration
REQ-025 SHALL, with INSTR_FIFO_PERF_EN defined, add outputs perf_empty_cycles and perf_full_cycles (32-bit, saturating), counting cycles with empty=1 and with write_en!=0 while full=1; cleared by rst, not by flush.
REQ-026 SHALL, without INSTR_FIFO_PERF_EN, omit those ports and counters entirely, other behaviour identical.

Verification
REQ-027 SHALL test: reset, then push two (A,B) in one cycle -> next cycle count=2, read_data={B,A}, read_valid=2'b11, empty=0, almost_empty=0.
REQ-028 SHALL test: count=1, issue_en=2'b11 -> pop clipped to 1, next cycle empty=1, read_valid=0.
REQ-029 SHALL test: DEPTH=16, count=15, write_en=2'b11 -> only slot0 accepted, count=16, full=1; slot1 lost.
REQ-030 SHALL test: count=16, write_en=2'b11, issue_en=2'b11 -> no push, pop 2, count=14; following cycle push 2 -> count=16.
REQ-031 SHALL test: 40 sequential pairs pushed/popped across pointer wrap -> output sequence equals input sequence.
REQ-032 SHALL test: count=5 with write_en=2'b11 and flush=1 -> next cycle count=0, empty=1; rst pulse mid-push gives same result immediately.

Source files
------------

// File: rtl/instr_fifo.sv
// Dual-slot instruction FIFO between fetch and issue.
// Up to two entries can be pushed and up to two popped per cycle. The head
// entry and the one behind it are always presented, with no read latency.
// Optional build macro: INSTR_FIFO_PERF_EN adds saturating occupancy
// performance counters (perf_empty_cycles, perf_full_cycles).
//
// Handshake: write_en[0] offers write_data[0] and write_en[1] offers
// write_data[1]. Slot1 counts only when slot0 is also offered and accepted.
// Free space is judged on the count from before this cycle's pops. On the
// read side, read_valid[n] qualifies read_data[n], and issue_en[n] consumes
// it at the next rising edge. issue_en[1] is ignored without issue_en[0],
// and pops beyond the stored count are ignored.

package instr_fifo_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } pipe_entry_t;

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic full;
        logic almost_full;
    } fifo_ctrl_t;
endpackage

module instr_fifo
    import instr_fifo_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        write_en,
    input  pipe_entry_t [1:0] write_data,
    input  logic [1:0]        issue_en,
    output pipe_entry_t [1:0] read_data,
    output logic [1:0]        read_valid,
`ifdef INSTR_FIFO_PERF_EN
    output logic [31:0]       perf_empty_cycles,
    output logic [31:0]       perf_full_cycles,
`endif
    output fifo_ctrl_t        fifo_ctrl
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] TWO_C   = (AW+1)'(2);

    pipe_entry_t mem [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic [AW:0]   free_slots;
    logic [AW:0]   pop_cnt;
    logic [AW:0]   push_cnt;
    logic          push0;
    logic          push1;

    // Accept/consume decisions from the registered occupancy.
    always_comb begin
        free_slots = DEPTH_C - count;
        push0      = write_en[0] && (free_slots >= ONE_C);
        push1      = push0 && write_en[1] && (free_slots >= TWO_C);
        push_cnt   = push1 ? TWO_C : (push0 ? ONE_C : '0);
        pop_cnt    = '0;
        if (issue_en[0]) begin
            if (issue_en[1] && count >= TWO_C) begin
                pop_cnt = TWO_C;
            end else if (count >= ONE_C) begin
                pop_cnt = ONE_C;
            end
        end
    end

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            rptr  <= rptr + pop_cnt[AW-1:0];
            wptr  <= wptr + push_cnt[AW-1:0];
            count <= count + push_cnt - pop_cnt;
        end
    end

    // Storage array write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push0) mem[wptr] <= write_data[0];
            if (push1) mem[wptr + AW'(1)] <= write_data[1];
        end
    end

    // Head and head+1 presentation plus status flags.
    always_comb begin
        read_data[0]           = mem[rptr];
        read_data[1]           = mem[rptr + AW'(1)];
        read_valid[0]          = (count >= ONE_C);
        read_valid[1]          = (count >= TWO_C);
        fifo_ctrl.empty        = (count == '0);
        fifo_ctrl.almost_empty = (count == ONE_C);
        fifo_ctrl.full         = (count == DEPTH_C);
        fifo_ctrl.almost_full  = (count >= DEPTH_C - ONE_C);
    end

`ifdef INSTR_FIFO_PERF_EN
    // Saturating occupancy counters; flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_empty_cycles <= '0;
            perf_full_cycles  <= '0;
        end else begin
            if (fifo_ctrl.empty && perf_empty_cycles != 32'hFFFF_FFFF)
                perf_empty_cycles <= perf_empty_cycles + 32'd1;
            if (fifo_ctrl.full && write_en != 2'b00 && perf_full_cycles != 32'hFFFF_FFFF)
                perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fifo.sv
// Directed testbench for instr_fifo (DEPTH=16).
module tb_instr_fifo;
    import instr_fifo_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [1:0]        write_en = 2'b00;
    pipe_entry_t [1:0] write_data = '0;
    logic [1:0]        issue_en = 2'b00;
    pipe_entry_t [1:0] read_data;
    logic [1:0]        read_valid;
`ifdef INSTR_FIFO_PERF_EN
    logic [31:0]       perf_empty_cycles;
    logic [31:0]       perf_full_cycles;
`endif
    fifo_ctrl_t        fifo_ctrl;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    instr_fifo #(.DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .write_en(write_en),
        .write_data(write_data),
        .issue_en(issue_en),
        .read_data(read_data),
        .read_valid(read_valid),
`ifdef INSTR_FIFO_PERF_EN
        .perf_empty_cycles(perf_empty_cycles),
        .perf_full_cycles(perf_full_cycles),
`endif
        .fifo_ctrl(fifo_ctrl)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    function automatic pipe_entry_t mk(input int v);
        pipe_entry_t e;
        e.pc   = 32'(v) * 32'd4;
        e.insn = 32'hA000_0000 + 32'(v);
        return e;
    endfunction

    // Driver: apply one cycle of inputs, return 1ns after the edge with inputs idle.
    task automatic drive(input logic [1:0] we, input logic [1:0] ie, input logic fl,
                         input int a, input int b);
        write_en      = we;
        issue_en      = ie;
        flush         = fl;
        write_data[0] = mk(a);
        write_data[1] = mk(b);
        @(posedge clk);
        #1;
        write_en = 2'b00;
        issue_en = 2'b00;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut.count !== 5'd0) begin
            errors++; $display("FAIL reset_count got %0d want 0", dut.count);
        end
        checks++;
        if (fifo_ctrl !== 4'b1000) begin
            errors++; $display("FAIL reset_ctrl got %b want 1000", fifo_ctrl);
        end
        checks++;
        if (read_valid !== 2'b00) begin
            errors++; $display("FAIL reset_valid got %b want 00", read_valid);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_two();
        drive(2'b11, 2'b00, 1'b0, 1, 2);
        checks++;
        if (dut.count !== 5'd2) begin
            errors++; $display("FAIL push2_count got %0d want 2", dut.count);
        end
        checks++;
        if (read_data[0] !== mk(1) || read_data[1] !== mk(2)) begin
            errors++; $display("FAIL push2_data got %h %h want %h %h",
                               read_data[0], read_data[1], mk(1), mk(2));
        end
        checks++;
        if (read_valid !== 2'b11) begin
            errors++; $display("FAIL push2_valid got %b want 11", read_valid);
        end
        checks++;
        if (fifo_ctrl !== 4'b0000) begin
            errors++; $display("FAIL push2_ctrl got %b want 0000", fifo_ctrl);
        end
    endtask

    task automatic test_pop_clip();
        drive(2'b00, 2'b01, 1'b0, 0, 0);
        checks++;
        if (read_data[0] !== mk(2) || read_valid !== 2'b01 || fifo_ctrl !== 4'b0100) begin
            errors++; $display("FAIL pop1_state got %h %b %b want %h 01 0100",
                               read_data[0], read_valid, fifo_ctrl, mk(2));
        end
        drive(2'b00, 2'b11, 1'b0, 0, 0);
        checks++;
        if (dut.count !== 5'd0 || fifo_ctrl.empty !== 1'b1) begin
            errors++; $display("FAIL popclip_empty got count %0d empty %b want 0 1",
                               dut.count, fifo_ctrl.empty);
        end
        checks++;
        if (read_valid !== 2'b00) begin
            errors++; $display("FAIL popclip_valid got %b want 00", read_valid);
        end
    endtask

    // Pop everything in exp_q, checking order and valids before each pop.
    task automatic drain(input string tag);
        int iter = 0;
        while (exp_q.size() > 0 && iter < 20) begin
            checks++;
            if (read_valid[0] !== 1'b1 || read_data[0] !== exp_q[0]) begin
                errors++; $display("FAIL %s_slot0 got %h v%b want %h", tag,
                                   read_data[0], read_valid[0], exp_q[0]);
            end
            if (exp_q.size() >= 2) begin
                checks++;
                if (read_valid[1] !== 1'b1 || read_data[1] !== exp_q[1]) begin
                    errors++; $display("FAIL %s_slot1 got %h v%b want %h", tag,
                                       read_data[1], read_valid[1], exp_q[1]);
                end
                drive(2'b00, 2'b11, 1'b0, 0, 0);
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
            end else begin
                drive(2'b00, 2'b01, 1'b0, 0, 0);
                void'(exp_q.pop_front());
            end
            iter++;
        end
        checks++;
        if (exp_q.size() != 0 || fifo_ctrl.empty !== 1'b1) begin
            errors++; $display("FAIL %s_drained got left %0d empty %b want 0 1", tag,
                               exp_q.size(), fifo_ctrl.empty);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) begin
            drive(2'b11, 2'b00, 1'b0, 10 + 2*i, 11 + 2*i);
            exp_q.push_back(mk(10 + 2*i));
            exp_q.push_back(mk(11 + 2*i));
        end
        drive(2'b01, 2'b00, 1'b0, 24, 0);
        exp_q.push_back(mk(24));
        checks++;
        if (dut.count !== 5'd15 || fifo_ctrl !== 4'b0001) begin
            errors++; $display("FAIL fill15 got count %0d ctrl %b want 15 0001",
                               dut.count, fifo_ctrl);
        end
        // Only slot0 fits; entry 31 must be dropped.
        drive(2'b11, 2'b00, 1'b0, 30, 31);
        exp_q.push_back(mk(30));
        checks++;
        if (dut.count !== 5'd16 || fifo_ctrl !== 4'b0011) begin
            errors++; $display("FAIL fullclip got count %0d ctrl %b want 16 0011",
                               dut.count, fifo_ctrl);
        end
        // Full: pop 2 frees space only from the next cycle, so no push now.
        drive(2'b11, 2'b11, 1'b0, 40, 41);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        checks++;
        if (dut.count !== 5'd14 || read_data[0] !== mk(12)) begin
            errors++; $display("FAIL fullsim got count %0d head %h want 14 %h",
                               dut.count, read_data[0], mk(12));
        end
        drive(2'b11, 2'b00, 1'b0, 42, 43);
        exp_q.push_back(mk(42));
        exp_q.push_back(mk(43));
        checks++;
        if (dut.count !== 5'd16 || fifo_ctrl.full !== 1'b1) begin
            errors++; $display("FAIL refill got count %0d full %b want 16 1",
                               dut.count, fifo_ctrl.full);
        end
        drain("fulldrain");
    endtask

    task automatic test_back_to_back();
        drive(2'b11, 2'b00, 1'b0, 100, 101);
        for (int i = 1; i < 40; i++) begin
            checks++;
            if (read_data[0] !== mk(100 + 2*(i-1)) || read_data[1] !== mk(101 + 2*(i-1))
                || read_valid !== 2'b11) begin
                errors++; $display("FAIL wrap_pair%0d got %h %h v%b want %h %h", i,
                                   read_data[0], read_data[1], read_valid,
                                   mk(100 + 2*(i-1)), mk(101 + 2*(i-1)));
            end
            drive(2'b11, 2'b11, 1'b0, 100 + 2*i, 101 + 2*i);
        end
        exp_q.push_back(mk(178));
        exp_q.push_back(mk(179));
        drain("wrapdrain");
    endtask

    task automatic test_flush();
        drive(2'b11, 2'b00, 1'b0, 200, 201);
        drive(2'b11, 2'b00, 1'b0, 202, 203);
        drive(2'b01, 2'b00, 1'b0, 204, 0);
        checks++;
        if (dut.count !== 5'd5) begin
            errors++; $display("FAIL flush_pre got %0d want 5", dut.count);
        end
        drive(2'b11, 2'b11, 1'b1, 205, 206);
        checks++;
        if (dut.count !== 5'd0 || fifo_ctrl !== 4'b1000 || read_valid !== 2'b00) begin
            errors++; $display("FAIL flush_clear got count %0d ctrl %b v%b want 0 1000 00",
                               dut.count, fifo_ctrl, read_valid);
        end
        drive(2'b11, 2'b00, 1'b0, 210, 211);
        write_en      = 2'b11;
        write_data[0] = mk(212);
        write_data[1] = mk(213);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.count !== 5'd0 || fifo_ctrl !== 4'b1000 || read_valid !== 2'b00) begin
            errors++; $display("FAIL rst_mid got count %0d ctrl %b v%b want 0 1000 00",
                               dut.count, fifo_ctrl, read_valid);
        end
        write_en = 2'b00;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (dut.count !== 5'd0) begin
            errors++; $display("FAIL rst_after got %0d want 0", dut.count);
        end
    endtask

    initial begin
        test_reset();
        test_push_two();
        test_pop_clip();
        test_full();
        test_back_to_back();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
